// File: rtl/alink_slave_mc.sv
// alink_slave_mc: Wishbone register slave for the multi-channel ALINK.
// Define ALINK_IRQ_EN to add the CTRL register and the RX-level irq.
module alink_slave_mc #(
   parameter int CH_NUM    = 4,
   parameter int FLUSH_LEN = 4,
   parameter int TXCNT_W   = 11,
   parameter int RXCNT_W   = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ALINK_STB_I,
   input  logic                  ALINK_WE_I,
   input  logic [7:0]            ALINK_ADR_I,
   input  logic [31:0]           ALINK_DAT_I,
   output logic                  ALINK_ACK_O,
   output logic                  ALINK_ERR_O,
   output logic [31:0]           ALINK_DAT_O,
   output logic                  txfifo_push,
   output logic [31:0]           txfifo_din,
   input  logic                  txfull,
   input  logic [TXCNT_W-1:0]    txcnt,
   output logic                  rxfifo_pop,
   input  logic [31:0]           rxfifo_dout,
   input  logic                  rxempty,
   input  logic [RXCNT_W-1:0]    rxcnt,
   output logic                  reg_flush,
   output logic [32*CH_NUM-1:0]  reg_mask,
   input  logic [32*CH_NUM-1:0]  busy,
   output logic                  alink_irq
);

   localparam logic [31:0] DEAD = 32'hdeaddead;
   localparam logic [3:0]  FLEN = 4'(FLUSH_LEN);

   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic        push_q, push_d;
   logic [31:0] din_q, din_d;
   logic [3:0]  fcnt_q, fcnt_d;
   logic        ovf_q, ovf_d;
   logic        udf_q, udf_d;
   logic [31:0] mask_q [CH_NUM];
   logic [31:0] mask_d [CH_NUM];

   logic        acc, wr, rd;
   logic        sel_tx, sel_st, sel_ctl, sel_rx;
   logic        sel_mk, sel_bz;
   logic [2:0]  idx;
   logic        idx_ok;
   logic [31:0] state_w, ctrl_w, rdata;
   logic [31:0] mk_rd, bz_rd;

   assign acc    = ALINK_STB_I & ~ack_q;
   assign wr     = acc & ALINK_WE_I;
   assign rd     = acc & ~ALINK_WE_I;
   assign idx    = ALINK_ADR_I[4:2];
   assign idx_ok = {29'd0, idx} < 32'(CH_NUM);

   assign sel_tx = ALINK_ADR_I == 8'h00;
   assign sel_st = ALINK_ADR_I == 8'h04;
   assign sel_rx = ALINK_ADR_I == 8'h10;
   assign sel_mk = (ALINK_ADR_I[7:5] == 3'b001) &
                   (ALINK_ADR_I[1:0] == 2'b00) & idx_ok;
   assign sel_bz = (ALINK_ADR_I[7:5] == 3'b010) &
                   (ALINK_ADR_I[1:0] == 2'b00) & idx_ok;

   assign state_w = {12'(rxcnt), 3'b000, rxempty,
                     12'(txcnt), udf_q, ovf_q,
                     reg_flush, txfull};

   // FWFT head is consumed in the same cycle the read is accepted
   assign rxfifo_pop = rd & sel_rx & ~rxempty;

   // bank lookup for MASK/BUSY reads
   always_comb begin
      mk_rd = '0;
      bz_rd = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (idx == 3'(i)) begin
            mk_rd = mask_q[i];
            bz_rd = busy[32*i +: 32];
         end
      end
   end

   // read data mux, unmapped reads give the dead pattern
   always_comb begin
      rdata = DEAD;
      unique case (1'b1)
         sel_st:  rdata = state_w;
         sel_ctl: rdata = ctrl_w;
         sel_rx:  rdata = rxempty ? DEAD : rxfifo_dout;
         sel_mk:  rdata = mk_rd;
         sel_bz:  rdata = bz_rd;
         default: rdata = DEAD;
      endcase
   end

   // next state for handshake, TX path, flush and sticky flags
   always_comb begin
      ack_d  = acc;
      dat_d  = dat_q;
      push_d = 1'b0;
      din_d  = din_q;
      fcnt_d = fcnt_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;
      if (fcnt_q != 4'd0) fcnt_d = fcnt_q - 4'd1;
      if (rd) dat_d = rdata;
      if (wr & sel_tx & ~txfull) begin
         push_d = 1'b1;
         din_d  = ALINK_DAT_I;
      end
      if (wr & sel_st) begin
         if (ALINK_DAT_I[1]) fcnt_d = FLEN;
         if (ALINK_DAT_I[2]) ovf_d = 1'b0;
         if (ALINK_DAT_I[3]) udf_d = 1'b0;
      end
      // a set event beats a same-cycle clear
      if (wr & sel_tx & txfull) ovf_d = 1'b1;
      if (rd & sel_rx & rxempty) udf_d = 1'b1;
   end

   // mask bank write
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         mask_d[i] = mask_q[i];
         if (wr & sel_mk & (idx == 3'(i)))
            mask_d[i] = ALINK_DAT_I;
      end
   end

   // core registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_q  <= 1'b0;
         dat_q  <= DEAD;
         push_q <= 1'b0;
         din_q  <= '0;
         fcnt_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         ack_q  <= ack_d;
         dat_q  <= dat_d;
         push_q <= push_d;
         din_q  <= din_d;
         fcnt_q <= fcnt_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   // mask bank registers
   always_ff @(posedge clk) begin
      for (int i = 0; i < CH_NUM; i++) begin
         if (!rst_n) mask_q[i] <= '0;
         else        mask_q[i] <= mask_d[i];
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_mask
      assign reg_mask[32*g +: 32] = mask_q[g];
   end

`ifdef ALINK_IRQ_EN
   logic [11:0] thr_q, thr_d;
   logic        ien_q, ien_d;
   logic        irq_q, irq_d;
   logic        lvl_hit;

   assign sel_ctl = ALINK_ADR_I == 8'h08;
   assign ctrl_w  = {15'd0, ien_q, 4'd0, thr_q};
   assign lvl_hit = (thr_q != 12'd0) &
                    (12'(rxcnt) >= thr_q);

   // CTRL update and interrupt condition
   always_comb begin
      thr_d = thr_q;
      ien_d = ien_q;
      if (wr & sel_ctl) begin
         thr_d = ALINK_DAT_I[11:0];
         ien_d = ALINK_DAT_I[16];
      end
      irq_d = ien_q & (lvl_hit | ovf_q | udf_q);
   end

   // CTRL and interrupt registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         thr_q <= '0;
         ien_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         thr_q <= thr_d;
         ien_q <= ien_d;
         irq_q <= irq_d;
      end
   end

   assign alink_irq = irq_q;
`else
   assign sel_ctl   = 1'b0;
   assign ctrl_w    = DEAD;
   assign alink_irq = 1'b0;
`endif

   assign ALINK_ACK_O = ack_q;
   assign ALINK_ERR_O = 1'b0;
   assign ALINK_DAT_O = dat_q;
   assign txfifo_push = push_q;
   assign txfifo_din  = din_q;
   assign reg_flush   = fcnt_q != 4'd0;

endmodule

// File: tb/tb_alink_slave_mc.sv
// tb_alink_slave_mc: scoreboard bench for alink_slave_mc.
// Directed test-plan items followed by random register traffic.
module tb_alink_slave_mc;

   localparam int CH = 4;
   localparam int FL = 4;
   localparam int TW = 11;
   localparam int RW = 10;

   logic            clk;
   logic            rst_n;
   logic            stb, we;
   logic [7:0]      adr;
   logic [31:0]     dat_i;
   logic            ack, err;
   logic [31:0]     dat_o;
   logic            txfifo_push;
   logic [31:0]     txfifo_din;
   logic            txfull;
   logic [TW-1:0]   txcnt;
   logic            rxfifo_pop;
   logic [31:0]     rxfifo_dout;
   logic            rxempty;
   logic [RW-1:0]   rxcnt;
   logic            reg_flush;
   logic [32*CH-1:0] reg_mask;
   logic [32*CH-1:0] busy;
   logic            alink_irq;

   alink_slave_mc #(
      .CH_NUM(CH), .FLUSH_LEN(FL),
      .TXCNT_W(TW), .RXCNT_W(RW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ALINK_STB_I(stb), .ALINK_WE_I(we),
      .ALINK_ADR_I(adr), .ALINK_DAT_I(dat_i),
      .ALINK_ACK_O(ack), .ALINK_ERR_O(err),
      .ALINK_DAT_O(dat_o),
      .txfifo_push(txfifo_push),
      .txfifo_din(txfifo_din),
      .txfull(txfull), .txcnt(txcnt),
      .rxfifo_pop(rxfifo_pop),
      .rxfifo_dout(rxfifo_dout),
      .rxempty(rxempty), .rxcnt(rxcnt),
      .reg_flush(reg_flush),
      .reg_mask(reg_mask), .busy(busy),
      .alink_irq(alink_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      logic [31:0] data;
      bit          push;
      logic [31:0] din;
   } exp_t;

   exp_t q[$];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int fhi_cnt = 0;
   bit chk_en = 0;
   logic prev_ack = 1'b0;
   logic irq_nxt = 1'b0;

   // reference model state
   logic [31:0] m_mask [CH];
   bit          m_ovf, m_udf;
   logic [11:0] m_thr;
   bit          m_en;
   int          fw_lo = 0;
   int          fw_hi = 0;
   int          m_pops = 0;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h",
                  nm, act, exp);
      end
   endtask

   function automatic logic flush_at(int c);
      return (c >= fw_lo) && (c < fw_hi);
   endfunction

   function automatic logic irq_f();
      return m_en &&
         ((m_thr != 0 && int'(rxcnt) >= int'(m_thr))
          || m_ovf || m_udf);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CH; i++) m_mask[i] = '0;
      m_ovf = 0;
      m_udf = 0;
      m_thr = '0;
      m_en  = 0;
   endtask

   // edge counter used as the model's time base
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: scoreboard pop on ACK plus per-cycle checks
   always @(negedge clk) begin : mon
      exp_t e;
      if (chk_en) begin
         check("ack_b2b", {31'd0, prev_ack & ack}, 0);
         check("err_o", {31'd0, err}, 0);
         check("reg_flush", {31'd0, reg_flush},
               {31'd0, flush_at(cyc)});
`ifdef ALINK_IRQ_EN
         check("alink_irq", {31'd0, alink_irq},
               {31'd0, irq_nxt});
`else
         check("alink_irq", {31'd0, alink_irq}, 0);
`endif
         if (ack) begin
            check("sb_nonempty", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               if (e.rd) check("rdata", dat_o, e.data);
               check("tx_push", {31'd0, txfifo_push},
                     {31'd0, e.push});
               if (e.push)
                  check("tx_din", txfifo_din, e.din);
               for (int i = 0; i < CH; i++)
                  check("reg_mask", reg_mask[32*i +: 32],
                        m_mask[i]);
            end
         end else begin
            check("tx_push_idle",
                  {31'd0, txfifo_push}, 0);
         end
      end
      prev_ack <= ack;
      irq_nxt  <= rst_n ? irq_f() : 1'b0;
      if (rxfifo_pop) pop_cnt <= pop_cnt + 1;
      if (reg_flush)  fhi_cnt <= fhi_cnt + 1;
   end

   // one bus transaction, entered and left at posedge+1
   task automatic bus(input bit w,
                      input logic [7:0] a8,
                      input logic [31:0] d);
      exp_t e;
      int a, mi, bi, ec;
      a  = int'(a8);
      mi = -1;
      bi = -1;
      if (a % 4 == 0 && a >= 32 && a < 32 + 4*CH)
         mi = (a - 32) / 4;
      if (a % 4 == 0 && a >= 64 && a < 64 + 4*CH)
         bi = (a - 64) / 4;
      stb = 1'b1; we = w; adr = a8; dat_i = d;
      e.rd = !w; e.data = 32'hdeaddead;
      e.push = 0; e.din = '0;
      if (!w) begin
         if (a == 4)
            e.data = {12'(rxcnt), 3'b000, rxempty,
                      12'(txcnt), m_udf, m_ovf,
                      flush_at(cyc), txfull};
`ifdef ALINK_IRQ_EN
         if (a == 8)
            e.data = {15'd0, m_en, 4'd0, m_thr};
`endif
         if (a == 16 && !rxempty) e.data = rxfifo_dout;
         if (mi >= 0) e.data = m_mask[mi];
         if (bi >= 0) e.data = busy[32*bi +: 32];
      end else if (a == 0 && !txfull) begin
         e.push = 1;
         e.din  = d;
      end
      q.push_back(e);
      @(posedge clk); #1;
      stb = 1'b0; we = 1'b0;
      ec = cyc;
      if (w) begin
         if (a == 0 && txfull) m_ovf = 1;
         if (a == 4) begin
            if (d[1]) begin
               fw_lo = ec;
               fw_hi = ec + FL;
            end
            if (d[2]) m_ovf = 0;
            if (d[3]) m_udf = 0;
         end
`ifdef ALINK_IRQ_EN
         if (a == 8) begin
            m_thr = d[11:0];
            m_en  = d[16];
         end
`endif
         if (mi >= 0) m_mask[mi] = d;
      end else if (a == 16) begin
         if (rxempty) m_udf = 1;
         else         m_pops++;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      if (fw_hi > cyc + 1) fw_hi = cyc + 1;
      model_reset();
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic rand_inputs();
      txfull      = 1'($urandom_range(0, 1));
      rxempty     = 1'($urandom_range(0, 1));
      txcnt       = TW'($urandom_range(0, 2047));
      rxcnt       = RW'($urandom_range(0, 1023));
      rxfifo_dout = $urandom;
      for (int i = 0; i < CH; i++)
         busy[32*i +: 32] = $urandom;
   endtask

   logic [7:0] alist [16] = '{
      8'h00, 8'h04, 8'h08, 8'h0C,
      8'h10, 8'h14, 8'h20, 8'h24,
      8'h28, 8'h2C, 8'h30, 8'h3C,
      8'h40, 8'h44, 8'h4C, 8'h50
   };

   initial begin : stim
      int s0;
      rst_n = 1'b0;
      stb = 0; we = 0; adr = '0; dat_i = '0;
      txfull = 0; txcnt = '0;
      rxfifo_dout = '0; rxempty = 1; rxcnt = '0;
      busy = '0;
      model_reset();

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ack", {31'd0, ack}, 0);
      check("rst_dat", dat_o, 32'hdeaddead);
      check("rst_flush", {31'd0, reg_flush}, 0);
      check("rst_push", {31'd0, txfifo_push}, 0);
      check("rst_din", txfifo_din, 0);
      check("rst_irq", {31'd0, alink_irq}, 0);
      for (int i = 0; i < CH; i++)
         check("rst_mask", reg_mask[32*i +: 32], 0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      chk_en = 1;

      bus(0, 8'h20, 0);

      txfull = 0;
      bus(1, 8'h00, 32'h12345678);
      txfull = 1;
      bus(1, 8'h00, 32'h87654321);
      bus(0, 8'h04, 0);
      bus(1, 8'h04, 32'h4);
      bus(0, 8'h04, 0);
      txfull = 0;

      s0 = fhi_cnt;
      bus(1, 8'h04, 32'h2);
      repeat (8) @(posedge clk);
      #1;
      check("flush_len", fhi_cnt - s0, 4);
      s0 = fhi_cnt;
      bus(1, 8'h04, 32'h2);
      bus(1, 8'h04, 32'h2);
      repeat (10) @(posedge clk);
      #1;
      check("flush_reload", fhi_cnt - s0, 6);

      rxcnt = 3; rxempty = 0;
      rxfifo_dout = 32'hCAFEBABE;
      s0 = pop_cnt;
      bus(0, 8'h10, 0);
      check("rx_single_pop", pop_cnt - s0, 1);
      rxempty = 1;
      s0 = pop_cnt;
      bus(0, 8'h10, 0);
      check("rx_no_pop", pop_cnt - s0, 0);
      bus(0, 8'h04, 0);

      bus(1, 8'h28, 32'hA5A5A5A5);
      check("mask2", reg_mask[95:64], 32'hA5A5A5A5);
      busy[63:32] = 32'h0F0F0F0F;
      bus(0, 8'h44, 0);
      bus(0, 8'h50, 0);
      bus(1, 8'h50, 32'h11111111);
      bus(0, 8'h08, 0);

`ifdef ALINK_IRQ_EN
      bus(1, 8'h04, 32'hC);
      rxcnt = 7;
      bus(1, 8'h08, 32'h10008);
      @(negedge clk);
      check("irq_below", {31'd0, alink_irq}, 0);
      @(posedge clk); #1;
      rxcnt = 8;
      @(negedge clk);
      check("irq_lag", {31'd0, alink_irq}, 0);
      @(negedge clk);
      check("irq_rise", {31'd0, alink_irq}, 1);
      @(posedge clk); #1;
      bus(1, 8'h08, 32'h8);
      @(negedge clk);
      check("irq_fall", {31'd0, alink_irq}, 0);
      @(posedge clk); #1;
`endif

      for (int n = 0; n < 300; n++) begin
         rand_inputs();
         bus(1'($urandom_range(0, 1)),
             alist[$urandom_range(0, 15)],
             $urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      bus(1, 8'h04, 32'h2);
      do_reset(2);
      bus(0, 8'h04, 0);
      bus(0, 8'h24, 0);

      repeat (5) @(posedge clk);
      #1;
      check("sb_drained", 32'(q.size()), 0);
      check("pop_total", pop_cnt, m_pops);
      $display("TB_RESULT checks=%0d failures=%0d",
               n_chk, n_err);
      $finish;
   end

endmodule
